// File: rtl/ws2812_decoder.sv
// WS2812B-style NZR decoder: synchronizes the serial LED stream, classifies each
// high pulse by width, assembles 24-bit LSB-first pixel words, tracks the pixel
// index within a frame and detects the long low latch gap that ends a frame.
module ws2812_decoder #(
    parameter int BIT_THRESH   = 24,
    parameter int MIN_HIGH     = 4,
    parameter int MAX_HIGH     = 64,
    parameter int RESET_CYCLES = 1000,
    parameter int CNT_W        = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    output logic [8:0]  pixel_index,
    output logic        frame_done,
    output logic        pulse_err
);

    localparam logic [CNT_W-1:0] GAP_C = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THR_C = CNT_W'(BIT_THRESH);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             din_meta, din_s;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [4:0]       bit_cnt, bit_cnt_nx;
    logic [23:0]      word, word_nx, pixel_nx;
    logic [8:0]       pixel_index_nx;
    logic             have_pix, have_pix_nx;
    logic             pixel_valid_nx, frame_done_nx, pulse_err_nx;

    assign cnt_inc = cnt + 1'b1;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

    // State, counters and output pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SYNC;
            cnt         <= '0;
            bit_cnt     <= '0;
            have_pix    <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            pulse_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            have_pix    <= have_pix_nx;
            pixel       <= pixel_nx;
            pixel_valid <= pixel_valid_nx;
            pixel_index <= pixel_index_nx;
            frame_done  <= frame_done_nx;
            pulse_err   <= pulse_err_nx;
        end
    end

    // Shift register holding the word under assembly; every bit is rewritten
    // before a commit, so it needs no reset.
    always_ff @(posedge clk) begin
        word <= word_nx;
    end

    // Next-state logic: pulse-width classification, word assembly, gap handling.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bit_cnt_nx     = bit_cnt;
        word_nx        = word;
        pixel_nx       = pixel;
        have_pix_nx    = have_pix;
        pixel_valid_nx = 1'b0;
        frame_done_nx  = 1'b0;
        pulse_err_nx   = 1'b0;
        // The index advances in the cycle after a word is presented.
        pixel_index_nx = pixel_valid ? pixel_index + 9'd1 : pixel_index;

        case (state)
            SYNC: begin
                if (din_s) begin
                    cnt_nx = '0;
                end else if (cnt != GAP_C) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == GAP_C) begin
                        state_nx       = LOW;
                        bit_cnt_nx     = '0;
                        pixel_index_nx = '0;
                        have_pix_nx    = 1'b0;
                    end
                end
            end

            LOW: begin
                if (din_s) begin
                    state_nx = HIGH;
                    cnt_nx   = CNT_W'(1);
                end else if (cnt != GAP_C) begin
                    cnt_nx = cnt_inc;
                    // Saturation at GAP_C makes this fire once per gap.
                    if (cnt_inc == GAP_C) begin
                        if (bit_cnt != 5'd0) begin
                            pulse_err_nx   = 1'b1;
                            bit_cnt_nx     = '0;
                            pixel_index_nx = '0;
                            have_pix_nx    = 1'b0;
                        end else if (have_pix) begin
                            frame_done_nx  = 1'b1;
                            pixel_index_nx = '0;
                            have_pix_nx    = 1'b0;
                        end
                    end
                end
            end

            HIGH: begin
                if (din_s) begin
                    if (cnt >= MAX_C) begin
                        pulse_err_nx = 1'b1;
                        state_nx     = SYNC;
                        cnt_nx       = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else if (cnt < MIN_C) begin
                    pulse_err_nx = 1'b1;
                    state_nx     = SYNC;
                    cnt_nx       = '0;
                end else begin
                    word_nx[bit_cnt] = (cnt >= THR_C);
                    state_nx         = LOW;
                    cnt_nx           = CNT_W'(1);
                    if (bit_cnt == 5'd23) begin
                        pixel_nx       = word_nx;
                        pixel_valid_nx = 1'b1;
                        bit_cnt_nx     = '0;
                        have_pix_nx    = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt + 5'd1;
                    end
                end
            end

            default: begin
                state_nx = SYNC;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Self-checking bench for ws2812_decoder: randomized NZR pulse streams checked
// against a pulse-level reference model of the decoding rules.
module tb_ws2812_decoder;

    localparam int BIT_THRESH   = 24;
    localparam int MIN_HIGH     = 4;
    localparam int MAX_HIGH     = 64;
    localparam int RESET_CYCLES = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [8:0]  pixel_index;
    logic        frame_done;
    logic        pulse_err;

    int n_checks = 0;
    int n_pass   = 0;

    ws2812_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .pulse_err   (pulse_err)
    );

    always #12.5 clk = ~clk;

    // Observed events
    logic [23:0] got_pix[$];
    int          got_idx[$];
    int          got_fd, got_err, got_excl;

    always @(negedge clk) begin
        if (pixel_valid) begin
            got_pix.push_back(pixel);
            got_idx.push_back(int'(pixel_index));
        end
        if (frame_done) got_fd++;
        if (pulse_err) got_err++;
        if (int'(pixel_valid) + int'(frame_done) + int'(pulse_err) > 1) got_excl++;
    end

    // Reference model: operates on whole pulses (high width, low width).
    bit          m_synced = 1'b0;
    bit          m_bits[$];
    int          m_idx = 0;
    int          m_npix = 0;
    logic [23:0] exp_pix[$];
    int          exp_idx[$];
    int          exp_fd, exp_err;

    function automatic void mdl_high(input int w);
        logic [23:0] wd;
        if (!m_synced) return;
        if (w < MIN_HIGH || w > MAX_HIGH) begin
            exp_err++;
            m_synced = 1'b0;
            m_bits.delete();
            return;
        end
        m_bits.push_back(w >= BIT_THRESH);
        if (m_bits.size() == 24) begin
            wd = '0;
            for (int i = 0; i < 24; i++) wd[i] = m_bits[i];
            exp_pix.push_back(wd);
            exp_idx.push_back(m_idx);
            m_idx = (m_idx + 1) % 512;
            m_npix++;
            m_bits.delete();
        end
    endfunction

    function automatic void mdl_low(input int len);
        if (len < RESET_CYCLES) return;
        if (!m_synced) begin
            m_synced = 1'b1;
        end else if (m_bits.size() != 0) begin
            exp_err++;
        end else if (m_npix > 0) begin
            exp_fd++;
        end
        m_bits.delete();
        m_idx  = 0;
        m_npix = 0;
    endfunction

    function automatic void mdl_reset();
        m_synced = 1'b0;
        m_bits.delete();
        m_idx  = 0;
        m_npix = 0;
    endfunction

    function automatic int rand_hi(input bit b);
        return b ? int'($urandom_range(30, 24)) : int'($urandom_range(20, 6));
    endfunction

    task automatic clear_all();
        got_pix.delete(); got_idx.delete();
        got_fd = 0; got_err = 0; got_excl = 0;
        exp_pix.delete(); exp_idx.delete();
        exp_fd = 0; exp_err = 0;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
        mdl_high(hi);
        mdl_low(lo);
    endtask

    task automatic low_gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
        mdl_low(n);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 0; i < 24; i++) pulse(rand_hi(w[i]), int'($urandom_range(10, 3)));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pixel !== 24'h0) $display("FAIL reset_pixel: got %h want 000000", pixel); else n_pass++;
        n_checks++; if (pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pixel_valid); else n_pass++;
        n_checks++; if (pixel_index !== 9'd0) $display("FAIL reset_index: got %0d want 0", pixel_index); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (pulse_err !== 1'b0) $display("FAIL reset_pulse_err: got %b want 0", pulse_err); else n_pass++;
        reset = 1'b1;
        mdl_reset();
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [23:0] w;
        clear_all();
        w = 24'h00b000;
        low_gap(1100);
        for (int i = 0; i < 24; i++) pulse(w[i] ? 33 : 17, w[i] ? 19 : 35);
        low_gap(2000);
        n_checks++; if (got_pix.size() != 1) $display("FAIL single_count: got %0d want 1", got_pix.size()); else n_pass++;
        if (got_pix.size() >= 1) begin
            n_checks++; if (got_pix[0] !== 24'h00b000) $display("FAIL single_pixel: got %h want 00b000", got_pix[0]); else n_pass++;
            n_checks++; if (got_idx[0] != 0) $display("FAIL single_index: got %0d want 0", got_idx[0]); else n_pass++;
        end
        n_checks++; if (got_fd != 1) $display("FAIL single_frame_done: got %0d want 1", got_fd); else n_pass++;
        n_checks++; if (got_err != 0) $display("FAIL single_err: got %0d want 0", got_err); else n_pass++;
    endtask

    task automatic test_frame();
        clear_all();
        for (int k = 0; k < 64; k++) send_word((k % 2 == 0) ? 24'hb05000 : 24'h0000b0);
        low_gap(1100);
        n_checks++; if (got_pix.size() != 64) $display("FAIL frame_count: got %0d want 64", got_pix.size()); else n_pass++;
        for (int k = 0; k < got_pix.size() && k < exp_pix.size(); k++) begin
            n_checks++; if (got_pix[k] !== exp_pix[k]) $display("FAIL frame_pixel[%0d]: got %h want %h", k, got_pix[k], exp_pix[k]); else n_pass++;
            n_checks++; if (got_idx[k] != k) $display("FAIL frame_index[%0d]: got %0d want %0d", k, got_idx[k], k); else n_pass++;
        end
        n_checks++; if (got_fd != 1) $display("FAIL frame_done_count: got %0d want 1", got_fd); else n_pass++;
        n_checks++; if (got_err != exp_err) $display("FAIL frame_err: got %0d want %0d", got_err, exp_err); else n_pass++;
    endtask

    task automatic test_threshold();
        logic [23:0] w;
        int k, j;
        clear_all();
        w = 24'($urandom);
        k = int'($urandom_range(11, 0));
        j = int'($urandom_range(23, 12));
        for (int i = 0; i < 24; i++)
            pulse((i == k) ? 23 : (i == j) ? 24 : rand_hi(w[i]), int'($urandom_range(10, 3)));
        low_gap(1100);
        n_checks++; if (got_pix.size() != 1) $display("FAIL thresh_count: got %0d want 1", got_pix.size()); else n_pass++;
        if (got_pix.size() >= 1 && exp_pix.size() >= 1) begin
            n_checks++; if (got_pix[0][k] !== 1'b0) $display("FAIL thresh_w23: got %b want 0", got_pix[0][k]); else n_pass++;
            n_checks++; if (got_pix[0][j] !== 1'b1) $display("FAIL thresh_w24: got %b want 1", got_pix[0][j]); else n_pass++;
            n_checks++; if (got_pix[0] !== exp_pix[0]) $display("FAIL thresh_pixel: got %h want %h", got_pix[0], exp_pix[0]); else n_pass++;
        end
        // Glitch pulse mid-word, then traffic without a gap is ignored.
        clear_all();
        for (int i = 0; i < 5; i++) pulse(rand_hi(1'($urandom)), 8);
        pulse(3, 8);
        send_word(24'($urandom));
        n_checks++; if (got_err != 1) $display("FAIL glitch_err: got %0d want 1", got_err); else n_pass++;
        n_checks++; if (got_pix.size() != 0) $display("FAIL glitch_no_valid: got %0d want 0", got_pix.size()); else n_pass++;
        low_gap(1100);
        send_word(24'($urandom));
        low_gap(1100);
        n_checks++; if (got_pix.size() != exp_pix.size()) $display("FAIL glitch_resume_count: got %0d want %0d", got_pix.size(), exp_pix.size()); else n_pass++;
        if (got_pix.size() >= 1 && exp_pix.size() >= 1) begin
            n_checks++; if (got_pix[0] !== exp_pix[0]) $display("FAIL glitch_resume_pixel: got %h want %h", got_pix[0], exp_pix[0]); else n_pass++;
        end
        n_checks++; if (got_fd != exp_fd) $display("FAIL glitch_frame_done: got %0d want %0d", got_fd, exp_fd); else n_pass++;
    endtask

    task automatic test_overlong();
        clear_all();
        pulse(100, 10);
        send_word(24'($urandom));
        n_checks++; if (got_err != 1) $display("FAIL overlong_err: got %0d want 1", got_err); else n_pass++;
        n_checks++; if (got_pix.size() != 0) $display("FAIL overlong_ignored: got %0d want 0", got_pix.size()); else n_pass++;
        low_gap(1100);
        send_word(24'($urandom));
        low_gap(1100);
        n_checks++; if (got_pix.size() != 1) $display("FAIL overlong_resume_count: got %0d want 1", got_pix.size()); else n_pass++;
        if (got_pix.size() >= 1 && exp_pix.size() >= 1) begin
            n_checks++; if (got_pix[0] !== exp_pix[0]) $display("FAIL overlong_resume_pixel: got %h want %h", got_pix[0], exp_pix[0]); else n_pass++;
            n_checks++; if (got_idx[0] != 0) $display("FAIL overlong_resume_index: got %0d want 0", got_idx[0]); else n_pass++;
        end
        n_checks++; if (got_fd != exp_fd) $display("FAIL overlong_frame_done: got %0d want %0d", got_fd, exp_fd); else n_pass++;
    endtask

    task automatic test_partial();
        clear_all();
        for (int i = 0; i < 10; i++) pulse(rand_hi(1'($urandom)), int'($urandom_range(10, 3)));
        low_gap(2000);
        n_checks++; if (got_err != 1) $display("FAIL partial_err: got %0d want 1", got_err); else n_pass++;
        n_checks++; if (got_fd != 0) $display("FAIL partial_frame_done: got %0d want 0", got_fd); else n_pass++;
        n_checks++; if (got_pix.size() != 0) $display("FAIL partial_valid: got %0d want 0", got_pix.size()); else n_pass++;
        send_word(24'($urandom));
        low_gap(1100);
        n_checks++; if (got_pix.size() != 1) $display("FAIL partial_next_count: got %0d want 1", got_pix.size()); else n_pass++;
        if (got_pix.size() >= 1 && exp_pix.size() >= 1) begin
            n_checks++; if (got_pix[0] !== exp_pix[0]) $display("FAIL partial_next_pixel: got %h want %h", got_pix[0], exp_pix[0]); else n_pass++;
            n_checks++; if (got_idx[0] != 0) $display("FAIL partial_next_index: got %0d want 0", got_idx[0]); else n_pass++;
        end
        n_checks++; if (got_fd != exp_fd) $display("FAIL partial_next_frame_done: got %0d want %0d", got_fd, exp_fd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_all();
        for (int i = 0; i < 12; i++) pulse(rand_hi(1'($urandom)), int'($urandom_range(10, 3)));
        reset = 1'b0;
        din   = 1'b0;
        mdl_reset();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        send_word(24'($urandom));
        low_gap(50);
        n_checks++; if (got_pix.size() + got_fd + got_err != 0) $display("FAIL resetmid_quiet: got %0d events want 0", got_pix.size() + got_fd + got_err); else n_pass++;
        low_gap(1100);
        send_word(24'($urandom));
        low_gap(1100);
        n_checks++; if (got_pix.size() != 1) $display("FAIL resetmid_count: got %0d want 1", got_pix.size()); else n_pass++;
        if (got_pix.size() >= 1 && exp_pix.size() >= 1) begin
            n_checks++; if (got_pix[0] !== exp_pix[0]) $display("FAIL resetmid_pixel: got %h want %h", got_pix[0], exp_pix[0]); else n_pass++;
            n_checks++; if (got_idx[0] != 0) $display("FAIL resetmid_index: got %0d want 0", got_idx[0]); else n_pass++;
        end
        n_checks++; if (got_fd != 1) $display("FAIL resetmid_frame_done: got %0d want 1", got_fd); else n_pass++;
        n_checks++; if (got_err != 0) $display("FAIL resetmid_err: got %0d want 0", got_err); else n_pass++;
    endtask

    task automatic test_exclusive();
        n_checks++; if (got_excl != 0) $display("FAIL pulse_exclusive: got %0d overlaps want 0", got_excl); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame();
        test_exclusive();
        test_threshold();
        test_overlong();
        test_partial();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
